// File: rtl/sram_byte_queue.sv
// Byte FIFO backed by an external 16-bit SRAM through a req/ready port, with an input skid FIFO.
// Optional drop counter output ovf_cnt is built when SRAM_QUEUE_OVF_CNT_EN is defined.
module sram_byte_queue #(
    parameter int ADDR_W    = 18,
    parameter int SKID_LOG2 = 2,
    parameter int AFULL_LVL = (1 << (ADDR_W + 1)) - 64
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic [7:0]        in_data,
    input  logic              in_vld,
    output logic              overflow,
    output logic              afull,
    output logic [ADDR_W+1:0] level,
    output logic              sram_req,
    input  logic              sram_ready,
    output logic              sram_rd,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [1:0]        sram_be,
    output logic [15:0]       sram_wr_data,
    input  logic              sram_rd_data_vld,
    input  logic [15:0]       sram_rd_data,
    output logic [7:0]        out_data,
    output logic              out_en,
    input  logic              out_ack
`ifdef SRAM_QUEUE_OVF_CNT_EN
    ,
    output logic [15:0]       ovf_cnt
`endif
);

    localparam int                SKID_D    = 1 << SKID_LOG2;
    localparam logic [ADDR_W+1:0] CAP_V     = {1'b1, {(ADDR_W + 1){1'b0}}};
    localparam logic [ADDR_W+1:0] AFULL_V   = (ADDR_W + 2)'(AFULL_LVL);
    localparam logic [SKID_LOG2:0] SKID_FULL = {1'b1, {SKID_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT} state_t;

    state_t               state;
    logic [7:0]           skid_mem [SKID_D];
    logic [SKID_LOG2-1:0] skid_wr_idx;
    logic [SKID_LOG2-1:0] skid_rd_idx;
    logic [SKID_LOG2:0]   skid_cnt;
    logic [ADDR_W:0]      wr_ptr;
    logic [ADDR_W:0]      rd_ptr;
    logic [ADDR_W+1:0]    sram_cnt;
    logic                 last_grant_rd;
    logic                 rd_lane;

    logic                 skid_push;
    logic                 skid_pop;
    logic                 rd_accept;
    logic                 wr_pend;
    logic                 rd_pend;
    logic [SKID_LOG2:0]   skid_cnt_nxt;
    logic [ADDR_W+1:0]    sram_cnt_nxt;
    logic [ADDR_W+1:0]    level_nxt;

    // NOTE: combinational logic uses blocking '=' with a default assigned first, so no latch is
    // inferred; every clocked register below uses '<='.
    always_comb begin
        skid_push = in_vld && (skid_cnt != SKID_FULL);
        skid_pop  = (state == WR_REQ) && sram_ready;
        rd_accept = (state == RD_REQ) && sram_ready;
        wr_pend   = (skid_cnt != '0) && (sram_cnt != CAP_V);
        rd_pend   = (sram_cnt != '0) && (!out_en || out_ack);

        skid_cnt_nxt = skid_cnt;
        if (skid_push && !skid_pop) begin
            skid_cnt_nxt = skid_cnt + (SKID_LOG2 + 1)'(1);
        end else if (!skid_push && skid_pop) begin
            skid_cnt_nxt = skid_cnt - (SKID_LOG2 + 1)'(1);
        end

        // Read count drops at acceptance so level never includes a byte already in flight.
        sram_cnt_nxt = sram_cnt;
        if (skid_pop) begin
            sram_cnt_nxt = sram_cnt + (ADDR_W + 2)'(1);
        end else if (rd_accept) begin
            sram_cnt_nxt = sram_cnt - (ADDR_W + 2)'(1);
        end

        level_nxt = sram_cnt_nxt + (ADDR_W + 2)'(skid_cnt_nxt);
    end

    // NOTE: the skid storage is deliberately not reset; skid_cnt alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (skid_push) begin
            skid_mem[skid_wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state         <= IDLE;
            skid_wr_idx   <= '0;
            skid_rd_idx   <= '0;
            skid_cnt      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            sram_cnt      <= '0;
            level         <= '0;
            afull         <= 1'b0;
            overflow      <= 1'b0;
            last_grant_rd <= 1'b1;
            rd_lane       <= 1'b0;
            sram_req      <= 1'b0;
            sram_rd       <= 1'b0;
            sram_addr     <= '0;
            sram_be       <= '0;
            sram_wr_data  <= '0;
            out_data      <= '0;
            out_en        <= 1'b0;
        end else begin
            if (skid_push) begin
                skid_wr_idx <= skid_wr_idx + SKID_LOG2'(1);
            end else if (in_vld) begin
                overflow <= 1'b1;
            end
            if (skid_pop) begin
                skid_rd_idx <= skid_rd_idx + SKID_LOG2'(1);
            end
            skid_cnt <= skid_cnt_nxt;
            sram_cnt <= sram_cnt_nxt;
            level    <= level_nxt;
            afull    <= (level_nxt >= AFULL_V);

            if (out_en && out_ack) begin
                out_en <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // Round robin when both sides want the SRAM; otherwise serve whichever does.
                    if (wr_pend && (!rd_pend || last_grant_rd)) begin
                        state         <= WR_REQ;
                        last_grant_rd <= 1'b0;
                        sram_req      <= 1'b1;
                        sram_rd       <= 1'b0;
                        sram_addr     <= wr_ptr[ADDR_W:1];
                        sram_be       <= wr_ptr[0] ? 2'b10 : 2'b01;
                        sram_wr_data  <= {2{skid_mem[skid_rd_idx]}};
                    end else if (rd_pend) begin
                        state         <= RD_REQ;
                        last_grant_rd <= 1'b1;
                        sram_req      <= 1'b1;
                        sram_rd       <= 1'b1;
                        sram_addr     <= rd_ptr[ADDR_W:1];
                        sram_be       <= 2'b11;
                    end
                end
                WR_REQ: begin
                    if (sram_ready) begin
                        sram_req <= 1'b0;
                        wr_ptr   <= wr_ptr + (ADDR_W + 1)'(1);
                        state    <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (sram_ready) begin
                        sram_req <= 1'b0;
                        rd_lane  <= rd_ptr[0];
                        rd_ptr   <= rd_ptr + (ADDR_W + 1)'(1);
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (sram_rd_data_vld) begin
                        out_data <= rd_lane ? sram_rd_data[15:8] : sram_rd_data[7:0];
                        out_en   <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SRAM_QUEUE_OVF_CNT_EN
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ovf_cnt <= '0;
        end else if (in_vld && !skid_push && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_byte_queue.sv
// Self-checking bench for sram_byte_queue: SRAM model with random ready, byte scoreboard,
// directed steps covering ordering, fill/overflow, wrap, round robin, reset and request hold.
module tb_sram_byte_queue;

    localparam int ADDR_W    = 4;
    localparam int SKID_LOG2 = 2;
    localparam int AFULL_LVL = 30;

    logic              clk;
    logic              reset_;
    logic [7:0]        in_data;
    logic              in_vld;
    logic              overflow;
    logic              afull;
    logic [ADDR_W+1:0] level;
    logic              sram_req;
    logic              sram_ready;
    logic              sram_rd;
    logic [ADDR_W-1:0] sram_addr;
    logic [1:0]        sram_be;
    logic [15:0]       sram_wr_data;
    logic              sram_rd_data_vld;
    logic [15:0]       sram_rd_data;
    logic [7:0]        out_data;
    logic              out_en;
    logic              out_ack;
`ifdef SRAM_QUEUE_OVF_CNT_EN
    logic [15:0]       ovf_cnt;
`endif

    sram_byte_queue #(
        .ADDR_W    (ADDR_W),
        .SKID_LOG2 (SKID_LOG2),
        .AFULL_LVL (AFULL_LVL)
    ) dut (
        .clk              (clk),
        .reset_           (reset_),
        .in_data          (in_data),
        .in_vld           (in_vld),
        .overflow         (overflow),
        .afull            (afull),
        .level            (level),
        .sram_req         (sram_req),
        .sram_ready       (sram_ready),
        .sram_rd          (sram_rd),
        .sram_addr        (sram_addr),
        .sram_be          (sram_be),
        .sram_wr_data     (sram_wr_data),
        .sram_rd_data_vld (sram_rd_data_vld),
        .sram_rd_data     (sram_rd_data),
        .out_data         (out_data),
        .out_en           (out_en),
        .out_ack          (out_ack)
`ifdef SRAM_QUEUE_OVF_CNT_EN
        ,
        .ovf_cnt          (ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sb [$];
    logic [1:0] be_log [$];
    bit         op_log [$];
    int         wr_count    = 0;
    int         rd_acc_count = 0;
    int         n_out       = 0;
    int         ready_mode  = 1;
    int         rd_lat      = 1;
    bit         ack_en      = 1'b1;
    logic [15:0] mem [16];
    int         rd_cnt      = 0;
    logic [15:0] rd_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SRAM model: acts on the falling edge, so the transfer it records happens on the next rising edge.
    always @(negedge clk) begin
        sram_rd_data_vld = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                sram_rd_data_vld = 1'b1;
                sram_rd_data     = rd_word;
            end
        end
        case (ready_mode)
            0:       sram_ready = ($urandom_range(0, 3) != 0);
            1:       sram_ready = 1'b1;
            default: sram_ready = 1'b0;
        endcase
        if (sram_req && sram_ready) begin
            if (sram_rd) begin
                rd_word = mem[sram_addr];
                rd_cnt  = rd_lat;
                op_log.push_back(1'b1);
                rd_acc_count++;
            end else begin
                if (sram_be[0]) mem[sram_addr][7:0]  = sram_wr_data[7:0];
                if (sram_be[1]) mem[sram_addr][15:8] = sram_wr_data[15:8];
                be_log.push_back(sram_be);
                op_log.push_back(1'b0);
                wr_count++;
            end
        end
    end

    // Transmitter model: acks each byte one cycle after it appears and checks it against the scoreboard.
    always @(negedge clk) begin
        if (out_ack) begin
            out_ack = 1'b0;
        end else if (ack_en && out_en) begin
            n_out++;
            if (sb.size() == 0) begin
                check("unexpected_out", 32'(out_data), 32'h100);
            end else begin
                check("out_data", 32'(out_data), 32'(sb.pop_front()));
            end
            out_ack = 1'b1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d, input bit keep);
        @(negedge clk);
        in_data = d;
        in_vld  = 1'b1;
        if (keep) sb.push_back(d);
        @(negedge clk);
        in_vld = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && level == '0 && !out_en) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_done", 32'(done), 32'd1);
    endtask

    task automatic wait_out_en(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_en) begin
                seen = 1'b1;
                break;
            end
        end
        check("out_en_seen", 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_ = 1'b0;
        cyc(2);
        reset_ = 1'b1;
        sb.delete();
        be_log.delete();
        op_log.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req"},    32'(sram_req), 32'd0);
        check({tag, "_out_en"}, 32'(out_en), 32'd0);
        check({tag, "_ovf"},    32'(overflow), 32'd0);
        check({tag, "_afull"},  32'(afull), 32'd0);
        check({tag, "_level"},  32'(level), 32'd0);
        check({tag, "_sram"},   32'({sram_rd, sram_addr, sram_be, sram_wr_data}), 32'd0);
        check({tag, "_odata"},  32'(out_data), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] held;
        bit          found;
        int          base;

        reset_  = 1'b0;
        in_vld  = 1'b0;
        in_data = 8'h00;
        out_ack = 1'b0;
        sram_ready = 1'b0;
        sram_rd_data_vld = 1'b0;
        sram_rd_data = 16'h0000;
        cyc(3);
        check_outputs_zero("rst");
        reset_ = 1'b1;
        cyc(2);
        check_outputs_zero("idle");

        // Slow trickle, random ready: in-order bytes and alternating write lanes.
        @(posedge clk);
        ready_mode = 0;
        ack_en     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(8'(i), 1'b1);
            cyc(8);
        end
        wait_drain(400);
        check("t1_level", 32'(level), 32'd0);
        check("t1_ovf", 32'(overflow), 32'd0);
        check("t1_nwrites", 32'(be_log.size()), 32'd10);
        for (int i = 0; i < be_log.size(); i++) begin
            check("t1_be", 32'(be_log[i]), (i % 2 == 1) ? 32'h2 : 32'h1);
        end

        // Fill with no acks: one byte parked in the output register, then SRAM and skid fill up.
        @(posedge clk);
        ready_mode = 1;
        ack_en     = 1'b0;
        push(8'hEE, 1'b1);
        wait_out_en(40);
        wr_count = 0;
        for (int k = 1; k <= 36; k++) begin
            push(8'(8'h10 + k), 1'b1);
            check("t2_afull_level", 32'({afull, level}), 32'(k) + ((k >= AFULL_LVL) ? 32'h40 : 32'h0));
            cyc(2);
        end
        cyc(6);
        check("t2_sram_writes", 32'(wr_count), 32'd32);
        push(8'hFF, 1'b0);
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_level_full", 32'(level), 32'd36);
`ifdef SRAM_QUEUE_OVF_CNT_EN
        check("t2_ovf_cnt", 32'(ovf_cnt), 32'd1);
`endif
        @(posedge clk);
        ack_en = 1'b1;
        wait_drain(800);
        check("t2_ovf_sticky", 32'(overflow), 32'd1);

        // Long stream with random ready: pointers wrap three times.
        do_reset();
        @(posedge clk);
        ready_mode = 0;
        ack_en     = 1'b1;
        wr_count   = 0;
        base       = n_out;
        for (int i = 0; i < 100; i++) begin
            push(8'(i * 37 + 5), 1'b1);
            cyc(14);
        end
        wait_drain(600);
        check("t3_nout", 32'(n_out - base), 32'd100);
        check("t3_nwrites", 32'(wr_count), 32'd100);
        check("t3_ovf", 32'(overflow), 32'd0);

        // Round robin: output parked, 8 bytes in SRAM, full skid stalled in a write, then release.
        do_reset();
        @(posedge clk);
        ready_mode = 1;
        ack_en     = 1'b0;
        push(8'h80, 1'b1);
        wait_out_en(40);
        for (int i = 0; i < 8; i++) begin
            push(8'(8'h81 + i), 1'b1);
            cyc(2);
        end
        cyc(4);
        @(posedge clk);
        ready_mode = 2;
        for (int i = 0; i < 4; i++) begin
            push(8'(8'h90 + i), 1'b1);
        end
        cyc(2);
        check("t4_level", 32'(level), 32'd12);
        op_log.delete();
        @(posedge clk);
        ready_mode = 1;
        ack_en     = 1'b1;
        wait_drain(300);
        check("t4_nops", 32'(op_log.size() >= 8), 32'd1);
        if (op_log.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                check("t4_rr_op", 32'(op_log[i]), 32'(i % 2));
            end
        end

        // Reset while a read is in flight; the late read strobe must be ignored.
        @(posedge clk);
        ready_mode = 1;
        ack_en     = 1'b1;
        rd_lat     = 10;
        base       = rd_acc_count;
        push(8'h3C, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rd_acc_count != base) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_read_issued", 32'(found), 32'd1);
        cyc(2);
        reset_ = 1'b0;
        cyc(1);
        check_outputs_zero("t5_rst");
        cyc(1);
        reset_ = 1'b1;
        sb.delete();
        cyc(14);
        check("t5_late_vld_ignored", 32'(out_en), 32'd0);
        rd_lat = 1;
        push(8'hA5, 1'b1);
        wait_drain(100);

        // Request fields must stay put while the SRAM withholds ready.
        @(posedge clk);
        ready_mode = 2;
        push(8'h5A, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sram_req) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t6_req_seen", 32'(found), 32'd1);
        held = {sram_req, sram_rd, sram_addr, sram_be, sram_wr_data};
        check("t6_fields", 32'(held), 32'({1'b1, 1'b0, 4'h0, 2'b10, 16'h5A5A}));
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            check("t6_hold", 32'({sram_req, sram_rd, sram_addr, sram_be, sram_wr_data}), 32'(held));
        end
        @(posedge clk);
        ready_mode = 1;
        wait_drain(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
